sensor_power_sequencer: RTL and testbench

Timed power-up/power-down sequencer for the SLVS-EC image sensor board. It sits directly downstream of the Nios II PIO control outputs. It converts a single software power request into correctly ordered, dwell-timed rail enables (1V2, 1V8, 3V3), the sensor input-clock enable (INCK_EN) and the reset release (XCLR). It gates XTRIG until the sensor is out of reset, and reports readiness so firmware starts SPI register configuration only when the sensor can accept it.

---
 rtl/sensor_power_sequencer.sv | 125 ++++++++++++
 tb/tb_sensor_power_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sensor_power_sequencer.sv
// Rail/INCK/XCLR power sequencer for the SLVS-EC sensor; every output is registered and moves on the edge that enters its state.
// Each timed state dwells exactly its parameter in cycles; there is no backpressure, and pwr_en_i is only acted on at dwell expiry.
module sensor_power_sequencer #(
    parameter int T_RAIL_CYC = 50000,
    parameter int T_INCK_CYC = 1000,
    parameter int T_XCLR_CYC = 500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pwr_en_i,
    input  logic       xtrig_i,
    output logic       reg_1v2_en_o,
    output logic       reg_1v8_en_o,
    output logic       reg_3v3_en_o,
    output logic       inck_en_o,
    output logic       xclr_o,
    output logic       xtrig_o,
    output logic       ready_o,
    output logic       busy_o,
    output logic [3:0] state_o
);
    localparam int T_MAX_A = (T_RAIL_CYC > T_INCK_CYC) ? T_RAIL_CYC : T_INCK_CYC;
    localparam int T_MAX   = (T_MAX_A > T_XCLR_CYC) ? T_MAX_A : T_XCLR_CYC;
    localparam int TW      = $clog2(T_MAX) + 1;

    typedef enum logic [3:0] {
        S_OFF     = 4'd0,
        S_UP_1V2  = 4'd1,
        S_UP_1V8  = 4'd2,
        S_UP_3V3  = 4'd3,
        S_UP_INCK = 4'd4,
        S_ON      = 4'd5,
        S_DN_XCLR = 4'd6,
        S_DN_INCK = 4'd7,
        S_DN_3V3  = 4'd8,
        S_DN_1V8  = 4'd9,
        S_DN_1V2  = 4'd10
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr, tmr_nxt;
    logic            tmr_exp;
    logic            r12_nxt, r18_nxt, r33_nxt, inck_nxt, xclr_nxt, busy_nxt;

    assign tmr_exp = (tmr == '0);
    assign state_o = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_OFF;
            tmr          <= '0;
            reg_1v2_en_o <= 1'b0;
            reg_1v8_en_o <= 1'b0;
            reg_3v3_en_o <= 1'b0;
            inck_en_o    <= 1'b0;
            xclr_o       <= 1'b0;
            ready_o      <= 1'b0;
            busy_o       <= 1'b0;
            xtrig_o      <= 1'b0;
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            reg_1v2_en_o <= r12_nxt;
            reg_1v8_en_o <= r18_nxt;
            reg_3v3_en_o <= r33_nxt;
            inck_en_o    <= inck_nxt;
            xclr_o       <= xclr_nxt;
            ready_o      <= xclr_nxt;
            busy_o       <= busy_nxt;
            // Uses the current state so the trigger drops on the edge that leaves S_ON.
            xtrig_o      <= xtrig_i & (state == S_ON) & pwr_en_i;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:     if (pwr_en_i) state_nxt = S_UP_1V2;
            // Aborts jump to the down state that removes the item just enabled.
            S_UP_1V2:  if (tmr_exp) state_nxt = pwr_en_i ? S_UP_1V8  : S_DN_1V2;
            S_UP_1V8:  if (tmr_exp) state_nxt = pwr_en_i ? S_UP_3V3  : S_DN_1V8;
            S_UP_3V3:  if (tmr_exp) state_nxt = pwr_en_i ? S_UP_INCK : S_DN_3V3;
            S_UP_INCK: if (tmr_exp) state_nxt = pwr_en_i ? S_ON      : S_DN_INCK;
            S_ON:      if (!pwr_en_i) state_nxt = S_DN_XCLR;
            S_DN_XCLR: if (tmr_exp) state_nxt = S_DN_INCK;
            S_DN_INCK: if (tmr_exp) state_nxt = S_DN_3V3;
            S_DN_3V3:  if (tmr_exp) state_nxt = S_DN_1V8;
            S_DN_1V8:  if (tmr_exp) state_nxt = S_DN_1V2;
            S_DN_1V2:  if (tmr_exp) state_nxt = S_OFF;
            default:   state_nxt = S_OFF;
        endcase

        tmr_nxt = tmr_exp ? tmr : tmr - 1'b1;
        if (state_nxt != state) begin
            case (state_nxt)
                S_UP_1V2, S_UP_1V8, S_UP_3V3,
                S_DN_INCK, S_DN_3V3, S_DN_1V8, S_DN_1V2: tmr_nxt = TW'(T_RAIL_CYC - 1);
                S_UP_INCK:                              tmr_nxt = TW'(T_INCK_CYC - 1);
                S_DN_XCLR:                              tmr_nxt = TW'(T_XCLR_CYC - 1);
                default:                                tmr_nxt = '0;
            endcase
        end
    end

    always_comb begin
        r12_nxt  = 1'b0;
        r18_nxt  = 1'b0;
        r33_nxt  = 1'b0;
        inck_nxt = 1'b0;
        xclr_nxt = 1'b0;
        busy_nxt = 1'b1;
        case (state_nxt)
            S_UP_1V2, S_DN_1V8:  r12_nxt = 1'b1;
            S_UP_1V8, S_DN_3V3:  {r12_nxt, r18_nxt} = 2'b11;
            S_UP_3V3, S_DN_INCK: {r12_nxt, r18_nxt, r33_nxt} = 3'b111;
            S_UP_INCK, S_DN_XCLR: {r12_nxt, r18_nxt, r33_nxt, inck_nxt} = 4'b1111;
            S_ON: begin
                {r12_nxt, r18_nxt, r33_nxt, inck_nxt, xclr_nxt} = 5'b11111;
                busy_nxt = 1'b0;
            end
            S_DN_1V2: busy_nxt = 1'b1;
            default:  busy_nxt = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_sensor_power_sequencer.sv
// Bench for sensor_power_sequencer: directed power-up/down/abort/trigger/reset scenarios against a level-based model.
module tb_sensor_power_sequencer;
    localparam int TR = 4;
    localparam int TI = 3;
    localparam int TX = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pwr_en_i = 1'b0;
    logic       xtrig_i = 1'b0;
    logic       reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o, inck_en_o;
    logic       xclr_o, xtrig_o, ready_o, busy_o;
    logic [3:0] state_o;

    sensor_power_sequencer #(.T_RAIL_CYC(TR), .T_INCK_CYC(TI), .T_XCLR_CYC(TX)) dut (
        .clk(clk), .reset(reset), .pwr_en_i(pwr_en_i), .xtrig_i(xtrig_i),
        .reg_1v2_en_o(reg_1v2_en_o), .reg_1v8_en_o(reg_1v8_en_o), .reg_3v3_en_o(reg_3v3_en_o),
        .inck_en_o(inck_en_o), .xclr_o(xclr_o), .xtrig_o(xtrig_o), .ready_o(ready_o),
        .busy_o(busy_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    logic run_cmp = 1'b0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Model: lvl = number of items on in order 1v2,1v8,3v3,inck,xclr; dir 0 idle, 1 up, 2 down; rem = edges left in dwell.
    int   m_lvl = 0;
    int   m_dir = 0;
    int   m_rem = 0;
    logic m_xtrig = 1'b0;

    function automatic int up_dwell(input int l);
        return (l <= 3) ? TR : ((l == 4) ? TI : 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_lvl <= 0; m_dir <= 0; m_rem <= 0; m_xtrig <= 1'b0;
        end else begin
            m_xtrig <= xtrig_i && pwr_en_i && (m_lvl == 5) && (m_dir == 1);
            case (m_dir)
                0: if (pwr_en_i) begin m_lvl <= 1; m_dir <= 1; m_rem <= TR; end
                1: begin
                    if (m_lvl == 5) begin
                        if (!pwr_en_i) begin m_lvl <= 4; m_dir <= 2; m_rem <= TX; end
                    end else if (m_rem == 1) begin
                        if (pwr_en_i) begin m_lvl <= m_lvl + 1; m_rem <= up_dwell(m_lvl + 1); end
                        else begin m_lvl <= m_lvl - 1; m_dir <= 2; m_rem <= TR; end
                    end else m_rem <= m_rem - 1;
                end
                default: begin
                    if (m_rem == 1) begin
                        if (m_lvl == 0) m_dir <= 0;
                        else begin m_lvl <= m_lvl - 1; m_rem <= TR; end
                    end else m_rem <= m_rem - 1;
                end
            endcase
        end
    end

    function automatic logic [11:0] exp_vec();
        logic [3:0] st;
        logic       bsy;
        st  = (m_dir == 0) ? 4'd0 : (m_dir == 1) ? 4'(m_lvl) : 4'(10 - m_lvl);
        bsy = (m_dir != 0) && !(m_dir == 1 && m_lvl == 5);
        return {m_lvl >= 1, m_lvl >= 2, m_lvl >= 3, m_lvl >= 4, m_lvl == 5,
                m_xtrig, m_lvl == 5, bsy, st};
    endfunction

    wire [11:0] dut_vec = {reg_1v2_en_o, reg_1v8_en_o, reg_3v3_en_o, inck_en_o, xclr_o,
                           xtrig_o, ready_o, busy_o, state_o};

    always @(negedge clk) begin
        if (run_cmp && !reset) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL model_cmp edge %0d got %b exp %b (12v 18v 33v inck xclr xtrig rdy busy st)",
                         edge_cnt, dut_vec, exp_vec());
            end
        end
    end

    logic ab_win = 1'b0;
    logic ab_bad = 1'b0;
    always @(negedge clk) if (ab_win && (reg_3v3_en_o || inck_en_o || xclr_o)) ab_bad <= 1'b1;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s edge %0d got %0d exp %0d", nm, edge_cnt, got, exp);
        end
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    int b, d, a, u;

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_vec", int'(dut_vec), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_cmp = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("off_hold_state", state_o, 0);
            chk("off_hold_1v2", reg_1v2_en_o, 0);
        end

        // Power-up with a trigger pulse while off.
        pwr_en_i = 1'b1; xtrig_i = 1'b1; b = edge_cnt;
        goto_edge(b + 1);
        chk("up_1v2_rise", reg_1v2_en_o, 1); chk("up_st1", state_o, 1); chk("up_xtrig_off", xtrig_o, 0);
        chk("up_busy1", busy_o, 1);
        xtrig_i = 1'b1;
        goto_edge(b + 2); chk("up_xtrig_s1", xtrig_o, 0); xtrig_i = 1'b0;
        goto_edge(b + 4); chk("up_1v8_pre", reg_1v8_en_o, 0);
        goto_edge(b + 5); chk("up_1v8_rise", reg_1v8_en_o, 1); chk("up_st2", state_o, 2);
        goto_edge(b + 9); chk("up_3v3_rise", reg_3v3_en_o, 1);
        goto_edge(b + 13); chk("up_inck_rise", inck_en_o, 1); chk("up_st4", state_o, 4);
        xtrig_i = 1'b1;
        goto_edge(b + 14); chk("up_xtrig_s4", xtrig_o, 0); xtrig_i = 1'b0;
        goto_edge(b + 15); chk("up_xclr_pre", xclr_o, 0); chk("up_busy15", busy_o, 1);
        goto_edge(b + 16);
        chk("up_xclr_rise", xclr_o, 1); chk("up_ready", ready_o, 1);
        chk("up_st5", state_o, 5); chk("up_busy_on", busy_o, 0);

        // Trigger pass-through in S_ON.
        xtrig_i = 1'b1;
        goto_edge(b + 17); chk("on_xtrig_hi", xtrig_o, 1); xtrig_i = 1'b0;
        goto_edge(b + 18); chk("on_xtrig_lo", xtrig_o, 0);

        // Power-down with a trigger in the falling cycle.
        goto_edge(b + 20);
        pwr_en_i = 1'b0; xtrig_i = 1'b1; d = edge_cnt;
        goto_edge(d + 1);
        chk("dn_xtrig_blocked", xtrig_o, 0); chk("dn_xclr_fall", xclr_o, 0);
        chk("dn_ready_fall", ready_o, 0); chk("dn_st6", state_o, 6);
        xtrig_i = 1'b0;
        goto_edge(d + 2); chk("dn_inck_hold", inck_en_o, 1);
        goto_edge(d + 3); chk("dn_inck_fall", inck_en_o, 0); chk("dn_st7", state_o, 7);
        goto_edge(d + 6); chk("dn_3v3_hold", reg_3v3_en_o, 1);
        goto_edge(d + 7); chk("dn_3v3_fall", reg_3v3_en_o, 0);
        goto_edge(d + 11); chk("dn_1v8_fall", reg_1v8_en_o, 0);
        goto_edge(d + 15); chk("dn_1v2_fall", reg_1v2_en_o, 0); chk("dn_st10", state_o, 10);
        goto_edge(d + 18); chk("dn_min_off", state_o, 10);
        goto_edge(d + 19); chk("dn_off", state_o, 0); chk("dn_busy_off", busy_o, 0);

        // Abort during S_UP_1V8.
        pwr_en_i = 1'b1; a = edge_cnt; ab_win = 1'b1;
        goto_edge(a + 6); pwr_en_i = 1'b0;
        goto_edge(a + 8); chk("ab_st2", state_o, 2);
        goto_edge(a + 9); chk("ab_st9", state_o, 9); chk("ab_1v8_off", reg_1v8_en_o, 0);
        chk("ab_1v2_on", reg_1v2_en_o, 1);
        goto_edge(a + 13); chk("ab_1v2_off", reg_1v2_en_o, 0); chk("ab_st10", state_o, 10);
        goto_edge(a + 17); chk("ab_off", state_o, 0);
        ab_win = 1'b0;
        chk("ab_never_later", ab_bad, 0);

        // Re-request during power-down.
        pwr_en_i = 1'b1; u = edge_cnt;
        goto_edge(u + 16); chk("rr_on", state_o, 5);
        pwr_en_i = 1'b0; d = edge_cnt;
        goto_edge(d + 3); chk("rr_st7", state_o, 7); pwr_en_i = 1'b1;
        goto_edge(d + 7); chk("rr_st8", state_o, 8);
        goto_edge(d + 15); chk("rr_st10", state_o, 10);
        goto_edge(d + 19); chk("rr_off", state_o, 0); chk("rr_1v2_lo", reg_1v2_en_o, 0);
        goto_edge(d + 20); chk("rr_restart", reg_1v2_en_o, 1); chk("rr_st1", state_o, 1);

        // Asynchronous reset in S_UP_3V3.
        goto_edge(d + 28); chk("rst_pre_st3", state_o, 3);
        #2 reset = 1'b1; pwr_en_i = 1'b0;
        #1 chk("rst_async_vec", int'(dut_vec), 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold_vec", int'(dut_vec), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
